// File: rtl/sram_slave.sv
// sram_slave: word-organised synchronous SRAM target for the memory
// controller's load/store bus. It adds programmable read/write wait states,
// byte-lane write merging and sticky out-of-range/collision error reporting.
module sram_slave #(
   parameter int ADDR_WIDTH    = 12,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        read_ack,
   input  logic        write_enable,
   input  logic [3:0]  write_byte_enable,
   input  logic [31:0] write_data,
   output logic        write_ack,
   output logic        bus_error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // The wait counter is preloaded with LATENCY-1 so the ack lands exactly
   // LATENCY edges after the accepting edge.
   localparam logic [3:0] RD_RELOAD = 4'(READ_LATENCY - 1);
   localparam logic [3:0] WR_RELOAD = 4'(WRITE_LATENCY - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_WAIT = 3'd1;
   localparam logic [2:0] WR_WAIT = 3'd2;
   localparam logic [2:0] RD_ACK  = 3'd3;
   localparam logic [2:0] WR_ACK  = 3'd4;

   logic [2:0]            state;
   logic [3:0]            wait_count;
   logic [ADDR_WIDTH-1:0] lat_index;
   logic                  lat_in_range;
   logic [31:0]           lat_data;
   logic [3:0]            lat_strobe;

   logic [31:0]           mem [DEPTH];

   logic [ADDR_WIDTH-1:0] req_index;
   logic                  req_in_range;
   logic                  commit_write;
   logic                  addr_lsb_unused;

   // Byte offset bits carry no meaning for a word-organised array.
   assign addr_lsb_unused = ^address[1:0];

   assign req_index    = address[ADDR_WIDTH+1:2];
   assign req_in_range = (address[31:ADDR_WIDTH+2] == '0);

   // The array is written on the very edge the FSM moves into WR_ACK, so a
   // reset that arrives earlier simply loses the pending write.
   assign commit_write = (state == WR_WAIT) && (wait_count == 4'd0) && lat_in_range;

   // Request sampling, wait-state countdown, ack pulses and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wait_count   <= 4'd0;
         lat_index    <= '0;
         lat_in_range <= 1'b0;
         lat_data     <= 32'd0;
         lat_strobe   <= 4'd0;
         read_data    <= 32'd0;
         read_ack     <= 1'b0;
         write_ack    <= 1'b0;
         bus_error    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (write_enable) begin
                  lat_index    <= req_index;
                  lat_in_range <= req_in_range;
                  lat_data     <= write_data;
                  lat_strobe   <= write_byte_enable;
                  wait_count   <= WR_RELOAD;
                  state        <= WR_WAIT;
                  if (read_enable) begin
                     bus_error <= 1'b1;
                  end
               end else if (read_enable) begin
                  lat_index    <= req_index;
                  lat_in_range <= req_in_range;
                  wait_count   <= RD_RELOAD;
                  state        <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (wait_count == 4'd0) begin
                  state     <= RD_ACK;
                  read_ack  <= 1'b1;
                  read_data <= lat_in_range ? mem[lat_index] : 32'd0;
                  if (!lat_in_range) begin
                     bus_error <= 1'b1;
                  end
               end else begin
                  wait_count <= wait_count - 4'd1;
               end
            end
            WR_WAIT: begin
               if (wait_count == 4'd0) begin
                  state     <= WR_ACK;
                  write_ack <= 1'b1;
                  if (!lat_in_range) begin
                     bus_error <= 1'b1;
                  end
               end else begin
                  wait_count <= wait_count - 4'd1;
               end
            end
            RD_ACK: begin
               read_ack <= 1'b0;
               state    <= IDLE;
            end
            WR_ACK: begin
               write_ack <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               read_ack  <= 1'b0;
               write_ack <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Lane-merged commit into the array; lanes with a clear strobe keep their byte.
   always_ff @(posedge clk) begin
      if (commit_write) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (lat_strobe[lane]) begin
               mem[lat_index][8*lane +: 8] <= lat_data[8*lane +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_slave.sv
// tb_sram_slave: scoreboard bench for sram_slave. Four instances with
// different wait-state settings share one clock and reset; one instance at a
// time is driven while a monitor checks every ack it raises against the
// expectation queued when the request was issued.
module tb_sram_slave;

   // Latency pairs per instance: (2,1) defaults, (1,3), (4,1), (15,3).
   localparam logic [15:0] RD_LATS = 16'hF412;
   localparam logic [15:0] WR_LATS = 16'h3131;

   typedef struct {
      bit          is_read;
      int          ack_cycle;
      logic [31:0] data;
      logic [31:0] mask;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic [3:0]  wbe;
   logic [31:0] wdata;
   logic        re [4];
   logic        we [4];
   logic [31:0] rd_data [4];
   logic        rd_ack [4];
   logic        wr_ack [4];
   logic        berr [4];

   int          cyc = 0;
   int          sel = 0;
   int          n_vec = 0;
   int          n_mis = 0;

   exp_t        sb [$];
   exp_t        mon_item;
   logic [31:0] model [int];
   logic [3:0]  known [int];
   bit          err_flag [4];

   always #5 clk = ~clk;

   // Edge counter used to time-stamp expected ack edges.
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sram_slave #(
         .ADDR_WIDTH   (12),
         .READ_LATENCY (int'(RD_LATS[4*g +: 4])),
         .WRITE_LATENCY(int'(WR_LATS[4*g +: 4]))
      ) dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .address          (address),
         .read_enable      (re[g]),
         .read_data        (rd_data[g]),
         .read_ack         (rd_ack[g]),
         .write_enable     (we[g]),
         .write_byte_enable(wbe),
         .write_data       (wdata),
         .write_ack        (wr_ack[g]),
         .bus_error        (berr[g])
      );
   end

   function automatic int rdLat(int s);
      return int'(RD_LATS[4*s +: 4]);
   endfunction

   function automatic int wrLat(int s);
      return int'(WR_LATS[4*s +: 4]);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("[TB] FAIL %s (dut %0d, cycle %0d): got 0x%08h, expected 0x%08h",
                  name, sel, cyc, act, exp);
      end
   endtask

   // Monitor: every ack on the active instance must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (rd_ack[sel] || wr_ack[sel])) begin
         if (sb.size() == 0) begin
            checkOutput("spuriousAck", {30'd0, rd_ack[sel], wr_ack[sel]}, 32'd0);
         end else begin
            mon_item = sb.pop_front();
            checkOutput("ackIsRead", {31'd0, rd_ack[sel]}, {31'd0, mon_item.is_read});
            checkOutput("ackIsWrite", {31'd0, wr_ack[sel]}, {31'd0, !mon_item.is_read});
            checkOutput("ackCycle", cyc, mon_item.ack_cycle);
            checkOutput("busError", {31'd0, berr[sel]}, {31'd0, mon_item.err});
            if (mon_item.is_read && mon_item.mask != 32'd0) begin
               checkOutput("readData", rd_data[sel] & mon_item.mask, mon_item.data & mon_item.mask);
            end
         end
      end
   end

   // Issue one request on the active instance, queue its expected response,
   // and wait (bounded) for the ack. Called and returns at a falling edge.
   task automatic applyStimulus(input bit is_read, input bit both, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] data);
      exp_t        e;
      bit          in_range;
      int          key;
      bit          got;
      logic [31:0] mask;
      in_range = (addr[31:14] == 18'd0);
      key      = sel * 4096 + int'(addr[13:2]);
      if (!is_read || both) begin
         if (in_range) begin
            if (!model.exists(key)) begin
               model[key] = 32'd0;
               known[key] = 4'd0;
            end
            for (int l = 0; l < 4; l++) begin
               if (be[l]) model[key][8*l +: 8] = data[8*l +: 8];
            end
            known[key] = known[key] | be;
         end else begin
            err_flag[sel] = 1'b1;
         end
         if (both) err_flag[sel] = 1'b1;
         e.is_read   = 1'b0;
         e.ack_cycle = cyc + 1 + wrLat(sel);
         e.data      = 32'd0;
         e.mask      = 32'd0;
      end else begin
         mask = 32'd0;
         if (in_range) begin
            if (model.exists(key)) begin
               for (int l = 0; l < 4; l++) begin
                  if (known[key][l]) mask[8*l +: 8] = 8'hFF;
               end
               e.data = model[key];
            end else begin
               e.data = 32'd0;
            end
         end else begin
            err_flag[sel] = 1'b1;
            mask   = 32'hFFFF_FFFF;
            e.data = 32'd0;
         end
         e.is_read   = 1'b1;
         e.ack_cycle = cyc + 1 + rdLat(sel);
         e.mask      = mask;
      end
      e.err = err_flag[sel];
      sb.push_back(e);

      address = addr;
      wbe     = be;
      wdata   = data;
      re[sel] = is_read || both;
      we[sel] = !is_read || both;
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (rd_ack[sel] || wr_ack[sel]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) checkOutput("ackTimeout", 32'd0, 32'd1);
      // Hold the enables through the IDLE-entry edge, as a real master would.
      @(negedge clk);
      re[sel] = 1'b0;
      we[sel] = 1'b0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         re[i] = 1'b0;
         we[i] = 1'b0;
         err_flag[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      sb.delete();
      rst_n = 1'b1;
   endtask

   task automatic checkResetState();
      for (int i = 0; i < 4; i++) begin
         checkOutput("resetReadData", rd_data[i], 32'd0);
         checkOutput("resetReadAck", {31'd0, rd_ack[i]}, 32'd0);
         checkOutput("resetWriteAck", {31'd0, wr_ack[i]}, 32'd0);
         checkOutput("resetBusError", {31'd0, berr[i]}, 32'd0);
      end
   endtask

   // Bound the whole run so a stuck handshake can never hang the simulation.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, randomized traffic per latency setting, reset aborts.
   initial begin
      int          ack_cnt;
      int          r;
      logic [31:0] a;
      rst_n   = 1'b0;
      address = 32'd0;
      wbe     = 4'd0;
      wdata   = 32'd0;
      for (int i = 0; i < 4; i++) begin
         re[i] = 1'b0;
         we[i] = 1'b0;
         err_flag[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkResetState();

      sel = 0;
      applyStimulus(1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'd0);
      checkOutput("roundTrip", rd_data[0], 32'hDEAD_BEEF);

      applyStimulus(1'b0, 1'b0, 32'h0000_0020, 4'hF, 32'h1122_3344);
      applyStimulus(1'b0, 1'b0, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'd0);
      checkOutput("laneMerge", rd_data[0], 32'h11BB_33DD);
      applyStimulus(1'b0, 1'b0, 32'h0000_0022, 4'b1100, 32'h5566_0000);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'd0);
      checkOutput("laneMergeUpper", rd_data[0], 32'h5566_33DD);

      applyStimulus(1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D);
      checkOutput("noErrorYet", {31'd0, berr[0]}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0000_4000, 4'hF, 32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 32'h0000_4000, 4'h0, 32'd0);
      checkOutput("outOfRangeRead", rd_data[0], 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'd0);
      checkOutput("wordZeroIntact", rd_data[0], 32'h0BAD_F00D);
      checkOutput("errorSticky", {31'd0, berr[0]}, 32'd1);

      applyStimulus(1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D);
      applyStimulus(1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'd0);
      checkOutput("collisionWrite", rd_data[0], 32'hCAFE_F00D);

      applyReset();
      checkResetState();

      for (int s = 0; s < 4; s++) begin
         sel = s;
         for (int n = 0; n < 25; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
               a = $urandom() | 32'h0000_4000;
            end else begin
               a = {18'd0, 7'd0, 5'($urandom_range(0, 31)), 2'($urandom())};
            end
            if (r == 1) begin
               applyStimulus(1'b0, 1'b1, a, 4'($urandom()), $urandom());
            end else if (r < 6) begin
               applyStimulus(1'b0, 1'b0, a, 4'($urandom()), $urandom());
            end else begin
               applyStimulus(1'b1, 1'b0, a, 4'h0, 32'd0);
            end
         end
         repeat (3) @(negedge clk);
         checkOutput("scoreboardDrained", sb.size(), 32'd0);
      end

      applyReset();

      // Read aborted by reset in RD_WAIT of a four-cycle read.
      sel = 2;
      applyStimulus(1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h7777_8888);
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'd0);
      checkOutput("preAbortRead", rd_data[2], 32'h7777_8888);
      address = 32'h0000_0100;
      re[2]   = 1'b1;
      repeat (2) @(negedge clk);
      applyReset();
      ack_cnt = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (rd_ack[2]) ack_cnt++;
      end
      checkOutput("abortedReadAcks", ack_cnt, 32'd0);
      checkOutput("abortedReadData", rd_data[2], 32'd0);

      // Write aborted by reset in WR_WAIT of a three-cycle write.
      sel = 1;
      applyStimulus(1'b0, 1'b0, 32'h0000_0040, 4'hF, 32'hA5A5_0001);
      address = 32'h0000_0040;
      wbe     = 4'hF;
      wdata   = 32'hFFFF_FFFF;
      we[1]   = 1'b1;
      repeat (2) @(negedge clk);
      applyReset();
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'd0);
      checkOutput("abortedWriteLost", rd_data[1], 32'hA5A5_0001);

      repeat (3) @(negedge clk);
      checkOutput("finalDrained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/sram_slave.md
Name: sram_slave

Overview:
- Word-organised synchronous SRAM target that serves the memory controller's load/store bus: address, read/write enables, byte-lane write strobes, and separate read/write acknowledges.
- Adds programmable wait states, byte-lane write merging and out-of-range detection. This lets the memory controller be exercised against non-zero memory latency.
- Sits directly downstream of the memory controller and replaces the zero-wait SRAM model in unit and system benches.

Parameters:
- ADDR_WIDTH, 12, word-index width; depth = 2**ADDR_WIDTH words (4096 words = 16 KiB).
- READ_LATENCY, 2, cycles from request acceptance to read_ack; legal range 1..15.
- WRITE_LATENCY, 1, cycles from request acceptance to write_ack; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- address  in  32  byte address; word index = address[ADDR_WIDTH+1:2]; address[1:0] ignored.
- read_enable  in  1  read request; held high by the master until read_ack is seen.
- read_data  out  32  read word, registered.
- read_ack  out  1  one-cycle read completion pulse.
- write_enable  in  1  write request; held high by the master until write_ack is seen.
- write_byte_enable  in  4  lane strobes; bit n covers write_data[8n+7:8n].
- write_data  in  32  lane-aligned write word.
- write_ack  out  1  one-cycle write completion pulse.
- bus_error  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, read_data = 0, read_ack = 0, write_ack = 0, bus_error = 0, wait counter = 0.
  - Array contents are not cleared.
- States: IDLE, RD_WAIT, WR_WAIT, RD_ACK, WR_ACK.
- IDLE, request sampling:
  - On an edge where write_enable = 1, latch address, data and strobes; go to WR_WAIT with counter = WRITE_LATENCY-1.
  - Else, on an edge where read_enable = 1, latch address; go to RD_WAIT with counter = READ_LATENCY-1.
  - Both enables high on the same edge: the write wins, the read is not accepted, and bus_error sets.
- RD_WAIT / WR_WAIT: decrement the counter each edge. At counter = 0, go to RD_ACK / WR_ACK; the ack register goes high on that same edge.
- Latency: a request accepted at edge k produces its ack high from edge k+LATENCY to edge k+LATENCY+1. With defaults, read ack is high 2 cycles after acceptance and write ack 1 cycle after acceptance.
- Read completion:
  - On the edge entering RD_ACK, read_data is loaded with mem[latched index], or 0 if out of range.
  - read_data holds that value until the next read completion.
- Write completion:
  - Commit happens on the edge entering WR_ACK: each lane with strobe = 1 overwrites its byte; lanes with strobe = 0 keep their old value.
  - Strobe 4'b0000: ack still issued, no change to memory.
- RD_ACK / WR_ACK:
  - The ack is high for exactly one cycle, then the FSM returns to IDLE and the ack clears.
  - The master deasserts the enable in the cycle after it samples the ack.
  - An enable still high on the IDLE entry edge is not sampled, because sampling occurs only while in IDLE.
  - Back-to-back minimum: one IDLE cycle between requests.
- Address and data inputs are don't-care after acceptance; the latched copies are used.
- Out-of-range (address[31:ADDR_WIDTH+2] != 0):
  - Request is still acknowledged with normal latency.
  - Write is dropped; read returns 0.
  - bus_error sets on the ack edge.
- Reset mid-transaction:
  - Pending access is aborted and no ack is issued.
  - An uncommitted write is lost; a write already committed (WR_ACK reached) persists.
- Word index wraps nowhere; only out-of-range applies.

Test Plan:
- Word round-trip: write 0xDEADBEEF to 0x00000010 with strobe 4'hF, then read 0x00000010 → write_ack 1 cycle after acceptance; read_ack 2 cycles after acceptance; read_data = 0xDEADBEEF.
- Lane merge: write 0x11223344 (strobe 4'hF) to 0x20, then 0xAABBCCDD with strobe 4'b0101, then read 0x20 → 0x11BB33DD. Address 0x22 with strobe 4'b1100 writing 0x55660000 then reads 0x556633DD.
- Latency sweep: READ_LATENCY ∈ {1, 4, 15}, WRITE_LATENCY ∈ {1, 3} → ack edge = acceptance edge + LATENCY exactly; ack width exactly 1 cycle; enable held across the wait does not create a second transaction.
- Out-of-range: write 0x12345678 to 0x00004000 (default depth), then read the same address → both acked; read_data = 0; bus_error = 1 and stays 1; read of 0x0 unaffected.
- Collision: read_enable and write_enable both high in IDLE with write_data 0xCAFEF00D at 0x8 → only write_ack pulses, no read_ack; bus_error = 1; subsequent read of 0x8 returns 0xCAFEF00D.
- Reset abort: assert rst_n low during RD_WAIT of a READ_LATENCY = 4 read → read_ack never pulses; read_data = 0; a write aborted in WR_WAIT leaves the previously written memory word unchanged.
